// File: rtl/dpram_wq.sv
// Two-port label memory with a write-deferral queue and per-entry written flags.
// Optional queue-to-read forwarding is enabled by defining DPRAM_FWD_EN.
module dpram_wq #(
    parameter int K = 128,
    parameter int S = 10,
    parameter int Q = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en_0,
    input  logic                   wr_en_1,
    input  logic [S-1:0]           wr_addr_0,
    input  logic [S-1:0]           wr_addr_1,
    input  logic [K-1:0]           wr_data_0,
    input  logic [K-1:0]           wr_data_1,
    input  logic                   rd_req_0,
    input  logic                   rd_req_1,
    input  logic [S-1:0]           rd_addr_0,
    input  logic [S-1:0]           rd_addr_1,
    output logic                   rd_valid_0,
    output logic                   rd_valid_1,
    output logic [K-1:0]           rd_data_0,
    output logic [K-1:0]           rd_data_1,
    output logic                   rd_ready_0,
    output logic                   rd_ready_1,
    output logic                   stall_rd,
    output logic [$clog2(Q+1)-1:0] wq_count
);
    localparam int CW  = $clog2(Q + 1);
    localparam int QIW = $clog2(Q);
    localparam int D   = 2 ** S;

    logic [K-1:0]   mem [D];
    logic [S-1:0]   q_addr_q [Q];
    logic [S-1:0]   q_addr_d [Q];
    logic [K-1:0]   q_data_q [Q];
    logic [K-1:0]   q_data_d [Q];
    logic [CW-1:0]  count_q, count_d;
    logic [D-1:0]   flag_q, flag_d;
    logic           rd_valid_0_q, rd_valid_0_d, rd_valid_1_q, rd_valid_1_d;
    logic           rd_ready_0_q, rd_ready_0_d, rd_ready_1_q, rd_ready_1_d;
    logic [K-1:0]   rd_data_0_q, rd_data_1_q;

    logic           hit_0, hit_1, rd_block, drain_mode, rd_acc_0, rd_acc_1;
    logic [K-1:0]   fwd_0, fwd_1;
    logic           cand_en [4];
    logic [S-1:0]   cand_addr [4];
    logic [K-1:0]   cand_data [4];
    logic           taken [4];
    logic           wa_en, wb_en, wa_commit;
    logic [S-1:0]   wa_addr, wb_addr;
    logic [K-1:0]   wa_data, wb_data;
    int             cnt, slots, used, n_drain, base;

    always_comb begin
        cnt   = int'(count_q);
        hit_0 = 1'b0;
        hit_1 = 1'b0;
        fwd_0 = '0;
        fwd_1 = '0;
        // Ascending scan so the newest matching entry wins.
        for (int i = 0; i < Q; i++) begin
            if (i < cnt && q_addr_q[i] == rd_addr_0) begin
                hit_0 = 1'b1;
                fwd_0 = q_data_q[i];
            end
            if (i < cnt && q_addr_q[i] == rd_addr_1) begin
                hit_1 = 1'b1;
                fwd_1 = q_data_q[i];
            end
        end
`ifdef DPRAM_FWD_EN
        rd_block = 1'b0;
`else
        rd_block = (rd_req_0 && hit_0) || (rd_req_1 && hit_1);
`endif
        drain_mode = (cnt >= Q - 1) || rd_block;
        stall_rd   = drain_mode;
        rd_acc_0   = rd_req_0 && !drain_mode && !clr;
        rd_acc_1   = rd_req_1 && !drain_mode && !clr;

        cand_en[0]   = cnt > 0;
        cand_addr[0] = q_addr_q[0];
        cand_data[0] = q_data_q[0];
        cand_en[1]   = cnt > 1;
        cand_addr[1] = q_addr_q[1];
        cand_data[1] = q_data_q[1];
        cand_en[2]   = wr_en_0;
        cand_addr[2] = wr_addr_0;
        cand_data[2] = wr_data_0;
        cand_en[3]   = wr_en_1;
        cand_addr[3] = wr_addr_1;
        cand_data[3] = wr_data_1;

        slots = clr ? 0 : (drain_mode ? 2 : 2 - int'(rd_acc_0) - int'(rd_acc_1));
        used    = 0;
        n_drain = 0;
        wa_en   = 1'b0;
        wa_addr = '0;
        wa_data = '0;
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        // Candidates are in age order; port A always receives the older write.
        for (int c = 0; c < 4; c++) begin
            taken[c] = 1'b0;
            if (cand_en[c] && used < slots) begin
                taken[c] = 1'b1;
                if (used == 0) begin
                    wa_en   = 1'b1;
                    wa_addr = cand_addr[c];
                    wa_data = cand_data[c];
                end else begin
                    wb_en   = 1'b1;
                    wb_addr = cand_addr[c];
                    wb_data = cand_data[c];
                end
                used = used + 1;
                if (c < 2) n_drain = n_drain + 1;
            end
        end
        wa_commit = wa_en && !(wb_en && wb_addr == wa_addr);

        for (int i = 0; i < Q; i++) begin
            q_addr_d[i] = q_addr_q[i];
            q_data_d[i] = q_data_q[i];
            if (i + n_drain < Q) begin
                q_addr_d[i] = q_addr_q[QIW'(i + n_drain)];
                q_data_d[i] = q_data_q[QIW'(i + n_drain)];
            end
        end
        base = cnt - n_drain;
        if (!clr && wr_en_0 && !taken[2] && base < Q) begin
            q_addr_d[QIW'(base)] = wr_addr_0;
            q_data_d[QIW'(base)] = wr_data_0;
            base = base + 1;
        end
        if (!clr && wr_en_1 && !taken[3] && base < Q) begin
            q_addr_d[QIW'(base)] = wr_addr_1;
            q_data_d[QIW'(base)] = wr_data_1;
            base = base + 1;
        end
        count_d = clr ? '0 : CW'(base);

        flag_d = flag_q;
        if (wr_en_0) flag_d[wr_addr_0] = 1'b1;
        if (wr_en_1) flag_d[wr_addr_1] = 1'b1;
        if (clr) flag_d = '0;

        rd_valid_0_d = rd_acc_0;
        rd_valid_1_d = rd_acc_1;
        rd_ready_0_d = rd_acc_0 ? flag_q[rd_addr_0] : (clr ? 1'b0 : rd_ready_0_q);
        rd_ready_1_d = rd_acc_1 ? flag_q[rd_addr_1] : (clr ? 1'b0 : rd_ready_1_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            flag_q       <= '0;
            rd_valid_0_q <= 1'b0;
            rd_valid_1_q <= 1'b0;
            rd_ready_0_q <= 1'b0;
            rd_ready_1_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            flag_q       <= flag_d;
            rd_valid_0_q <= rd_valid_0_d;
            rd_valid_1_q <= rd_valid_1_d;
            rd_ready_0_q <= rd_ready_0_d;
            rd_ready_1_q <= rd_ready_1_d;
        end
    end

    // Queue payload needs no reset: entries at or beyond count_q are never used.
    always_ff @(posedge clk) begin
        q_addr_q <= q_addr_d;
        q_data_q <= q_data_d;
    end

    always_ff @(posedge clk) begin
        if (wa_commit) mem[wa_addr] <= wa_data;
        if (wb_en)     mem[wb_addr] <= wb_data;
    end

    // Read-old RAM output register; holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_data_0_q <= '0;
            rd_data_1_q <= '0;
        end else begin
            if (rd_acc_0) rd_data_0_q <= hit_0 ? fwd_0 : mem[rd_addr_0];
            if (rd_acc_1) rd_data_1_q <= hit_1 ? fwd_1 : mem[rd_addr_1];
        end
    end

    assign rd_valid_0 = rd_valid_0_q;
    assign rd_valid_1 = rd_valid_1_q;
    assign rd_ready_0 = rd_ready_0_q;
    assign rd_ready_1 = rd_ready_1_q;
    assign rd_data_0  = rd_data_0_q;
    assign rd_data_1  = rd_data_1_q;
    assign wq_count   = count_q;
endmodule
